// File: rtl/fir_filter_n.sv
`default_nettype none
// ============================================================================
// Module      : fir_filter_n
// Description : Streaming unsigned N-tap FIR filter with writable coefficients,
//               round-half-up post shift, output saturation, bypass and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_filter_n #(
    parameter int WIDTH = 8,
    parameter int TAPS  = 4,
    parameter int CW    = 4,
    parameter int SHIFT = 2
) (
    input  logic                     CLK,
    input  logic                     RSTN,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     flush,
    input  logic                     bypass,
    input  logic                     coef_wr,
    input  logic [$clog2(TAPS)-1:0]  coef_idx,
    input  logic [CW-1:0]            coef_data,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     primed
);

    localparam int c_IW   = $clog2(TAPS);
    // Sum width is wide enough for TAPS full-scale products without overflow
    localparam int c_SW   = WIDTH + CW + c_IW;
    localparam int c_CNTW = c_IW;
    localparam logic [c_SW:0]     c_MAX  = {{(c_SW + 1 - WIDTH){1'b0}}, {WIDTH{1'b1}}};
    localparam logic [c_CNTW-1:0] c_FULL = c_CNTW'(TAPS - 1);

    logic [WIDTH-1:0]  r_hist [1:TAPS-1];
    logic [CW-1:0]     r_coef [0:TAPS-1];
    logic [c_CNTW-1:0] r_count;
    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;

    logic [c_SW-1:0]   w_sum;
    logic [c_SW:0]     w_rnd;
    logic [WIDTH-1:0]  w_sat;
    logic [WIDTH-1:0]  w_next_out;
    logic              w_idx_ok;

    // Multiply-accumulate over the current window; a flush in the same cycle
    // makes the sample see an empty history.
    always_comb begin
        w_sum = c_SW'(r_coef[0]) * c_SW'(in_data);
        for (int k = 1; k < TAPS; k++) begin
            w_sum = w_sum + c_SW'(r_coef[k]) * (flush ? '0 : c_SW'(r_hist[k]));
        end
    end

    // Rounding post-shift; the extra top bit absorbs the rounding carry
    generate
        if (SHIFT == 0) begin : g_noshift
            assign w_rnd = {1'b0, w_sum};
        end else begin : g_round
            localparam logic [c_SW:0] c_HALF = (c_SW + 1)'(1) << (SHIFT - 1);
            assign w_rnd = ({1'b0, w_sum} + c_HALF) >> SHIFT;
        end
    endgenerate

    // Clamp to full scale, then choose between filtered and raw sample
    always_comb begin
        w_sat      = (w_rnd > c_MAX) ? {WIDTH{1'b1}} : w_rnd[WIDTH-1:0];
        w_next_out = bypass ? in_data : w_sat;
        w_idx_ok   = (32'(coef_idx) < TAPS);
    end

    // Output register: one-cycle latency, data held between samples
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out_data <= w_next_out;
            end
        end
    end

    // Sample history and primed count; flush clears before the new sample lands
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 1; k < TAPS; k++) begin
                r_hist[k] <= '0;
            end
            r_count <= '0;
        end else if (flush) begin
            for (int k = 2; k < TAPS; k++) begin
                r_hist[k] <= '0;
            end
            r_hist[1] <= in_valid ? in_data : '0;
            r_count   <= in_valid ? c_CNTW'(1) : '0;
        end else if (in_valid) begin
            for (int k = 2; k < TAPS; k++) begin
                r_hist[k] <= r_hist[k-1];
            end
            r_hist[1] <= in_data;
            if (r_count != c_FULL) begin
                r_count <= r_count + c_CNTW'(1);
            end
        end
    end

    // Coefficient bank; a write only takes effect for later samples
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            for (int k = 0; k < TAPS; k++) begin
                r_coef[k] <= '0;
            end
            r_coef[0] <= CW'(1);
            r_coef[1] <= CW'(2);
            r_coef[2] <= CW'(1);
        end else if (coef_wr && w_idx_ok) begin
            r_coef[coef_idx] <= coef_data;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign primed    = (r_count == c_FULL);

endmodule
`default_nettype wire

// File: tb/tb_fir_filter_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_filter_n
// Description : Self-checking bench for fir_filter_n (default parameters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_filter_n;

    localparam int WIDTH = 8;
    localparam int TAPS  = 4;
    localparam int CW    = 4;
    localparam int SHIFT = 2;

    logic             CLK = 1'b0;
    logic             RSTN;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             flush;
    logic             bypass;
    logic             coef_wr;
    logic [1:0]       coef_idx;
    logic [CW-1:0]    coef_data;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             primed;

    int errors = 0;
    int checks = 0;

    // Reference state: plain integers describing what the filter should hold
    int   m_hist [1:TAPS-1];
    int   m_coef [0:TAPS-1];
    int   m_cnt;
    logic m_v;
    int   m_d;

    fir_filter_n #(.WIDTH(WIDTH), .TAPS(TAPS), .CW(CW), .SHIFT(SHIFT)) dut (
        .CLK(CLK), .RSTN(RSTN), .in_valid(in_valid), .in_data(in_data),
        .flush(flush), .bypass(bypass), .coef_wr(coef_wr), .coef_idx(coef_idx),
        .coef_data(coef_data), .out_valid(out_valid), .out_data(out_data),
        .primed(primed)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        for (int k = 1; k < TAPS; k++) m_hist[k] = 0;
        for (int k = 0; k < TAPS; k++) m_coef[k] = 0;
        m_coef[0] = 1; m_coef[1] = 2; m_coef[2] = 1;
        m_cnt = 0; m_v = 1'b0; m_d = 0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (out_valid === m_v) else begin
            errors++;
            $error("FAIL %s out_valid: observed=%0b expected=%0b", tag, out_valid, m_v);
        end
        checks++;
        assert (out_data === WIDTH'(m_d)) else begin
            errors++;
            $error("FAIL %s out_data: observed=%0d expected=%0d", tag, out_data, m_d);
        end
        checks++;
        assert (primed === (m_cnt == TAPS - 1)) else begin
            errors++;
            $error("FAIL %s primed: observed=%0b expected=%0b", tag, primed, (m_cnt == TAPS - 1));
        end
    endtask

    // One clock cycle: drive inputs, advance the model, check after the edge.
    // want >= 0 also compares out_data against a hand-derived constant.
    task automatic step(input string tag, input logic v, input int d, input logic f,
                        input logic b, input logic cw, input int ci, input int cd,
                        input int want);
        int s, r;
        in_valid = v; in_data = WIDTH'(d); flush = f; bypass = b;
        coef_wr = cw; coef_idx = 2'(ci); coef_data = CW'(cd);
        if (v) begin
            s = m_coef[0] * d;
            for (int k = 1; k < TAPS; k++) s += m_coef[k] * (f ? 0 : m_hist[k]);
            r = (SHIFT == 0) ? s : ((s + (1 << (SHIFT - 1))) >> SHIFT);
            if (r > (1 << WIDTH) - 1) r = (1 << WIDTH) - 1;
            m_d = b ? d : r;
            m_v = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        if (f) begin
            for (int k = 1; k < TAPS; k++) m_hist[k] = 0;
            m_cnt = 0;
        end
        if (v) begin
            for (int k = TAPS - 1; k > 1; k--) m_hist[k] = m_hist[k-1];
            m_hist[1] = d;
            m_cnt = (m_cnt + 1 > TAPS - 1) ? TAPS - 1 : m_cnt + 1;
        end
        if (cw && ci < TAPS) m_coef[ci] = cd;
        @(posedge CLK);
        #1;
        check_outputs(tag);
        if (want >= 0) begin
            checks++;
            assert (out_data === WIDTH'(want)) else begin
                errors++;
                $error("FAIL %s directed: observed=%0d expected=%0d", tag, out_data, want);
            end
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_data = '0; flush = 1'b0; bypass = 1'b0;
        coef_wr = 1'b0; coef_idx = '0; coef_data = '0;
    endtask

    // Asynchronous reset: outputs must clear with no clock edge in between
    task automatic do_reset(input string tag);
        idle_inputs();
        RSTN = 1'b0;
        #2;
        model_reset();
        check_outputs(tag);
        @(negedge CLK);
        RSTN = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RSTN = 1'b1;
        idle_inputs();
        model_reset();
        #1;
        do_reset("reset0");

        // Default coefficients on a short ramp
        step("ramp4",  1, 4,  0, 0, 0, 0, 0, 1);
        step("ramp8",  1, 8,  0, 0, 0, 0, 0, 4);
        step("ramp12", 1, 12, 0, 0, 0, 0, 0, 8);
        step("idle",   0, 99, 0, 0, 0, 0, 0, 8);

        // All coefficients at full scale saturate the output
        do_reset("reset_sat");
        for (int i = 0; i < TAPS; i++) step("cwr", 0, 0, 0, 0, 1, i, 15, -1);
        step("sat255", 1, 255, 0, 0, 0, 0, 0, 255);

        // Bypass passes raw samples but still feeds the history
        do_reset("reset_byp");
        step("byp7",   1, 7,   0, 1, 0, 0, 0, 7);
        step("byp200", 1, 200, 0, 1, 0, 0, 0, 200);
        step("post_byp", 1, 0, 0, 0, 0, 0, 0, 102);

        // Flush together with a sample
        do_reset("reset_fl");
        step("fl_a", 1, 8, 0, 0, 0, 0, 0, -1);
        step("fl_b", 1, 8, 0, 0, 0, 0, 0, -1);
        step("fl_c", 1, 8, 0, 0, 0, 0, 0, -1);
        step("flush8", 1, 8, 1, 0, 0, 0, 0, 2);
        step("after_fl", 1, 8, 0, 0, 0, 0, 0, 6);

        // Coefficient write alongside a sample applies to the next one
        do_reset("reset_cw");
        step("cw_same", 1, 4, 0, 0, 1, 0, 0, 1);
        step("cw_next", 1, 4, 0, 0, 0, 0, 0, 2);

        // Reset mid-stream
        do_reset("reset_mid0");
        step("mid_a", 1, 50, 0, 0, 0, 0, 0, -1);
        step("mid_b", 1, 60, 0, 0, 0, 0, 0, -1);
        do_reset("reset_mid");
        step("mid_after", 1, 4, 0, 0, 0, 0, 0, 1);

        // Randomised traffic against the reference model
        for (int i = 0; i < 300; i++) begin
            step("rand",
                 logic'($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 255)),
                 logic'($urandom_range(0, 19) == 0),
                 logic'($urandom_range(0, 9) == 0),
                 logic'($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 15)),
                 -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fir_filter_n.md
FIR_FILTER_N -- requirements
Module: fir_filter_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the sample width in bits (unsigned).
REQ-002 The block SHALL have parameter TAPS, default 4, giving the number of taps; legal range 3..16.
REQ-003 The block SHALL have parameter CW, default 4, giving the coefficient width in bits (unsigned).
REQ-004 The block SHALL have parameter SHIFT, default 2, giving the post-sum right shift; legal range 0..8.
REQ-005 The block SHALL have port CLK, input, 1 bit: the single clock, rising-edge active.
REQ-006 The block SHALL have port RSTN, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: in_data carries a sample this cycle.
REQ-008 The block SHALL have port in_data, input, WIDTH bits: input sample.
REQ-009 The block SHALL have port flush, input, 1 bit: clear sample history.
REQ-010 The block SHALL have port bypass, input, 1 bit: pass samples through unfiltered.
REQ-011 The block SHALL have port coef_wr, input, 1 bit: coefficient write strobe.
REQ-012 The block SHALL have port coef_idx, input, clog2(TAPS) bits: index of the coefficient to write.
REQ-013 The block SHALL have port coef_data, input, CW bits: coefficient write value.
REQ-014 The block SHALL have port out_valid, output, 1 bit: out_data carries a result this cycle.
REQ-015 The block SHALL have port out_data, output, WIDTH bits: filtered result.
REQ-016 The block SHALL have port primed, output, 1 bit: the history holds TAPS-1 real samples.

Function
REQ-017 The block SHALL keep a history x[1..TAPS-1] of the most recently accepted samples; x[1] is the newest.
REQ-018 On each cycle with in_valid=1, the block SHALL form the window w[0]=in_data, w[k]=x[k] for k=1..TAPS-1.
REQ-019 On the same edge, the block SHALL shift the history: x[1]<=in_data and x[k]<=x[k-1].
REQ-020 The block SHALL compute sum = Σ c[k]*w[k] for k=0..TAPS-1 in WIDTH+CW+clog2(TAPS) bits, with no intermediate truncation.
REQ-021 The block SHALL compute result = (sum + 2^(SHIFT-1)) >> SHIFT, rounding half up; when SHIFT=0, result = sum.
REQ-022 The block SHALL saturate result to 2^WIDTH-1 whenever it exceeds that value.
REQ-023 The block SHALL register out_data and out_valid with a latency of exactly 1 cycle from the accepting edge; back-to-back inputs SHALL give back-to-back outputs.
REQ-024 In cycles without in_valid, the block SHALL drive out_valid=0 on the next cycle, hold out_data at its last value, and leave the history unchanged.
REQ-025 When bypass=1 and in_valid=1, the block SHALL set out_data=in_data one cycle later; the history SHALL still shift and the primed count SHALL still advance.
REQ-026 When coef_wr=1, the block SHALL load c[coef_idx]<=coef_data; an index of TAPS or above SHALL be ignored.
REQ-027 A coefficient written in the same cycle as a sample SHALL NOT affect that sample; it SHALL apply from the next sample onward.
REQ-028 When flush=1, the block SHALL clear every x[k] to 0 and the primed count to 0.
REQ-029 When flush=1 and in_valid=1 occur in the same cycle, the block SHALL compute the sample with zero history, then load x[1]=in_data and set the count to 1.
REQ-030 The block SHALL keep a count of accepted samples that saturates at TAPS-1; primed SHALL be 1 exactly when the count equals TAPS-1.
REQ-031 Outputs SHALL still be produced before primed=1, computed with zero-filled history.

Reset
REQ-032 While RSTN=0, the block SHALL immediately (asynchronously) force out_valid=0, out_data=0, primed=0, all x[k]=0, and count=0.
REQ-033 While RSTN=0, the block SHALL force coefficients to c[0]=1, c[1]=2, c[2]=1, and all other c[k]=0.
REQ-034 Reset asserted mid-stream SHALL discard any in-flight result; the first sample after release SHALL see zero history.

Verification
REQ-035 Defaults after reset, in_data = 4, 8, 12 on consecutive cycles -> out_data = 1, 4, 8 with out_valid high 1 cycle later each; primed=1 after the 3rd sample.
REQ-036 Write all four coefficients to 15, then in_data=255 -> out_data=255 (saturated; raw result 956).
REQ-037 bypass=1, in_data = 7, 200 -> out_data = 7, 200 at latency 1; then bypass=0, in_data=0 -> out_data = (0+400+7+2)>>2 = 102.
REQ-038 After samples 8, 8, 8, assert flush together with in_data=8 -> out_data=2 and primed=0; the next sample 8 -> out_data=6.
REQ-039 coef_wr with coef_idx=0 and coef_data=0 in the same cycle as in_data=4 (defaults, empty history) -> out_data=1; the next in_data=4 -> out_data=2.
REQ-040 Pull RSTN low between two samples of a stream -> out_valid, out_data, and primed go to 0 without a clock edge; after release, in_data=4 -> out_data=1.
